cu_datapath: RTL and testbench

//   Core execution datapath under the control unit: the 8-bit program counter, an 8x8-bit register file

---
 rtl/cu_pkg.sv | 26 ++
 rtl/cu_datapath_if.sv | 35 +++
 rtl/alu_core.sv | 74 +++++++
 rtl/cu_datapath.sv | 55 +++++
 tb/tb_cu_datapath.sv | 108 ++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared widths, ALU function codes and flag bit positions for the datapath
package cu_pkg;
  localparam int DW = 8;
  localparam int NREG = 8;
  localparam int RW = $clog2(NREG);
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_MUL = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_NOT = 4'h6;
  localparam logic [3:0] ALU_NEG = 4'h7;
  localparam logic [3:0] ALU_INC = 4'h8;
  localparam logic [3:0] ALU_DEC = 4'h9;
  localparam logic [3:0] ALU_LSL = 4'hA;
  localparam logic [3:0] ALU_LSR = 4'hB;
  localparam logic [3:0] ALU_ASR = 4'hC;
  localparam logic [3:0] ALU_ROL = 4'hD;
  localparam logic [3:0] ALU_ROR = 4'hE;
  localparam logic [3:0] ALU_PASS = 4'hF;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
endpackage

// File: rtl/cu_datapath_if.sv
// cu_datapath_if: control-unit to datapath bus covering PC, register file and ALU
interface cu_datapath_if;
  import cu_pkg::*;
  logic pc_jump;
  logic [DW-1:0] pc_jump_addr;
  logic pc_hold;
  logic [DW-1:0] pc;
  logic [DW-1:0] pc_next;
  logic rf_read_en;
  logic rf_write_en;
  logic [RW-1:0] rf_ra;
  logic [RW-1:0] rf_rb;
  logic [RW-1:0] rf_rc;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_whi;
  logic [DW-1:0] rf_rdata_a;
  logic [DW-1:0] rf_rdata_b;
  logic [DW-1:0] rf_hi;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0] alu_fsel;
  logic [DW-1:0] alu_lo;
  logic [DW-1:0] alu_hi;
  logic [3:0] alu_flags;
  modport master (
    output pc_jump, pc_jump_addr, pc_hold, rf_read_en, rf_write_en, rf_ra, rf_rb, rf_rc,
           rf_wdata, rf_whi, alu_a, alu_b, alu_fsel,
    input pc, pc_next, rf_rdata_a, rf_rdata_b, rf_hi, alu_lo, alu_hi, alu_flags
  );
  modport slave (
    input pc_jump, pc_jump_addr, pc_hold, rf_read_en, rf_write_en, rf_ra, rf_rb, rf_rc,
          rf_wdata, rf_whi, alu_a, alu_b, alu_fsel,
    output pc, pc_next, rf_rdata_a, rf_rdata_b, rf_hi, alu_lo, alu_hi, alu_flags
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational 16-function ALU producing a 16-bit result and {V,N,Z,C} flags
module alu_core
  import cu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    fsel,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi,
  output logic [3:0]    flags
);
  logic c;
  logic v;
  // Result, carry and overflow per function; hi stays zero except for MUL
  always_comb begin
    lo = '0;
    hi = '0;
    c = 1'b0;
    v = 1'b0;
    case (fsel)
      ALU_ADD: begin
        {c, lo} = {1'b0, a} + {1'b0, b};
        v = (a[DW-1] == b[DW-1]) && (lo[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        lo = a - b;
        c = a < b;
        v = (a[DW-1] != b[DW-1]) && (lo[DW-1] != a[DW-1]);
      end
      ALU_MUL: begin
        {hi, lo} = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        c = |hi;
      end
      ALU_AND: lo = a & b;
      ALU_OR: lo = a | b;
      ALU_XOR: lo = a ^ b;
      ALU_NOT: lo = ~a;
      ALU_NEG: begin
        lo = '0 - a;
        c = |a;
        v = a[DW-1] & ~|a[DW-2:0];
      end
      ALU_INC: begin
        {c, lo} = {1'b0, a} + (DW+1)'(1);
        v = ~a[DW-1] & &a[DW-2:0];
      end
      ALU_DEC: begin
        lo = a - DW'(1);
        c = ~|a;
        v = a[DW-1] & ~|a[DW-2:0];
      end
      ALU_LSL: {c, lo} = {a, 1'b0};
      ALU_LSR: {lo, c} = {1'b0, a};
      ALU_ASR: {lo, c} = {a[DW-1], a};
      ALU_ROL: begin
        lo = {a[DW-2:0], a[DW-1]};
        c = a[DW-1];
      end
      ALU_ROR: begin
        lo = {a[0], a[DW-1:1]};
        c = a[0];
      end
      default: lo = a;
    endcase
  end
  // Pack flags; Z covers the full product and N comes from hi for MUL
  always_comb begin
    flags = '0;
    flags[FLAG_C] = c;
    flags[FLAG_Z] = ~|{hi, lo};
    flags[FLAG_N] = (fsel == ALU_MUL) ? hi[DW-1] : lo[DW-1];
    flags[FLAG_V] = v;
  end
endmodule

// File: rtl/cu_datapath.sv
// cu_datapath: program counter, register file with HI register, and ALU under control-unit direction
module cu_datapath
  import cu_pkg::*;
(
  input logic clk,
  input logic rst,
  cu_datapath_if.slave bus
);
  logic [DW-1:0] pc_q, pc_d;
  logic [NREG-1:0][DW-1:0] regs_q, regs_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  // Next PC: jump beats hold, otherwise increment with natural wrap
  always_comb begin
    pc_d = bus.pc_jump ? bus.pc_jump_addr : bus.pc_hold ? pc_q : pc_q + DW'(1);
  end
  // Register file next state; reads sample the pre-write contents so there is no bypass
  always_comb begin
    regs_d = regs_q;
    if (bus.rf_write_en) regs_d[bus.rf_rc] = bus.rf_wdata;
    hi_d = bus.rf_write_en ? bus.rf_whi : hi_q;
    rdata_a_d = bus.rf_read_en ? regs_q[bus.rf_ra] : rdata_a_q;
    rdata_b_d = bus.rf_read_en ? regs_q[bus.rf_rb] : rdata_b_q;
  end
  // State registers; reset clears everything and masks every enable
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      regs_q <= '0;
      hi_q <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      pc_q <= pc_d;
      regs_q <= regs_d;
      hi_q <= hi_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end
  assign bus.pc = pc_q;
  assign bus.pc_next = pc_d;
  assign bus.rf_rdata_a = rdata_a_q;
  assign bus.rf_rdata_b = rdata_b_q;
  assign bus.rf_hi = hi_q;
  alu_core u_alu (
    .a(bus.alu_a),
    .b(bus.alu_b),
    .fsel(bus.alu_fsel),
    .lo(bus.alu_lo),
    .hi(bus.alu_hi),
    .flags(bus.alu_flags)
  );
endmodule

// File: tb/tb_cu_datapath.sv
// tb_cu_datapath: directed checks of PC sequencing, register file timing and ALU results/flags
module tb_cu_datapath;
  import cu_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fails = 0;
  cu_datapath_if bus ();
  cu_datapath dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input string tag, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] hi, input logic [7:0] lo, input logic [3:0] fl);
    bus.alu_fsel = f;
    bus.alu_a = a;
    bus.alu_b = b;
    #1;
    chk(tag, {bus.alu_hi, bus.alu_lo, bus.alu_flags}, {hi, lo, fl});
  endtask
  initial begin
    rst = 1'b1;
    bus.pc_jump = 0; bus.pc_jump_addr = 0; bus.pc_hold = 0;
    bus.rf_read_en = 0; bus.rf_write_en = 0;
    bus.rf_ra = 0; bus.rf_rb = 0; bus.rf_rc = 0; bus.rf_wdata = 0; bus.rf_whi = 0;
    bus.alu_a = 0; bus.alu_b = 0; bus.alu_fsel = 0;
    step();
    chk("reset_pc", 20'(bus.pc), 20'h0);
    chk("reset_rd", 20'({bus.rf_rdata_a, bus.rf_rdata_b}), 20'h0);
    chk("reset_hi", 20'(bus.rf_hi), 20'h0);
    rst = 1'b0;
    step(); chk("pc_inc1", 20'(bus.pc), 20'h1);
    step(); chk("pc_inc2", 20'(bus.pc), 20'h2);
    step(); chk("pc_inc3", 20'(bus.pc), 20'h3);
    bus.pc_jump = 1; bus.pc_jump_addr = 8'hFF;
    step(); chk("pc_jump_ff", 20'(bus.pc), 20'hFF);
    bus.pc_jump = 0;
    step(); chk("pc_wrap", 20'(bus.pc), 20'h0);
    bus.pc_hold = 1;
    #1; chk("pc_next_hold", 20'(bus.pc_next), 20'h0);
    step(); chk("pc_hold1", 20'(bus.pc), 20'h0);
    step(); chk("pc_hold2", 20'(bus.pc), 20'h0);
    bus.pc_jump = 1; bus.pc_jump_addr = 8'h40;
    #1; chk("pc_next_jump", 20'(bus.pc_next), 20'h40);
    step(); chk("pc_jump_over_hold", 20'(bus.pc), 20'h40);
    bus.pc_jump = 0; bus.pc_hold = 0;
    bus.rf_write_en = 1; bus.rf_rc = 3; bus.rf_wdata = 8'h5A; bus.rf_whi = 8'h77;
    step(); chk("hi_write", 20'(bus.rf_hi), 20'h77);
    bus.rf_rc = 0; bus.rf_wdata = 8'hC3; bus.rf_whi = 8'h12;
    step();
    bus.rf_write_en = 0; bus.rf_read_en = 1; bus.rf_ra = 3; bus.rf_rb = 0;
    step(); chk("read_r3_r0", 20'({bus.rf_rdata_a, bus.rf_rdata_b}), 20'h5AC3);
    chk("hi_second", 20'(bus.rf_hi), 20'h12);
    bus.rf_write_en = 1; bus.rf_rc = 3; bus.rf_wdata = 8'h11; bus.rf_whi = 8'h00;
    step(); chk("read_old_same_edge", 20'(bus.rf_rdata_a), 20'h5A);
    bus.rf_write_en = 0;
    step(); chk("read_new", 20'(bus.rf_rdata_a), 20'h11);
    bus.rf_read_en = 0; bus.rf_ra = 0;
    step(); chk("read_hold", 20'(bus.rf_rdata_a), 20'h11);
    alu("add_ovf", ALU_ADD, 8'h7F, 8'h01, 8'h00, 8'h80, 4'b1100);
    alu("add_carry", ALU_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011);
    alu("sub_borrow", ALU_SUB, 8'h03, 8'h05, 8'h00, 8'hFE, 4'b0101);
    alu("sub_ovf", ALU_SUB, 8'h80, 8'h01, 8'h00, 8'h7F, 4'b1000);
    alu("mul_ff", ALU_MUL, 8'hFF, 8'hFF, 8'hFE, 8'h01, 4'b0101);
    alu("mul_zero", ALU_MUL, 8'h00, 8'h12, 8'h00, 8'h00, 4'b0010);
    alu("mul_small", ALU_MUL, 8'h10, 8'h03, 8'h00, 8'h30, 4'b0000);
    alu("and", ALU_AND, 8'hF0, 8'h3C, 8'h00, 8'h30, 4'b0000);
    alu("or", ALU_OR, 8'h81, 8'h02, 8'h00, 8'h83, 4'b0100);
    alu("xor_zero", ALU_XOR, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0010);
    alu("not", ALU_NOT, 8'h0F, 8'h00, 8'h00, 8'hF0, 4'b0100);
    alu("neg_80", ALU_NEG, 8'h80, 8'h00, 8'h00, 8'h80, 4'b1101);
    alu("neg_0", ALU_NEG, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010);
    alu("inc_7f", ALU_INC, 8'h7F, 8'h00, 8'h00, 8'h80, 4'b1100);
    alu("inc_ff", ALU_INC, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0011);
    alu("dec_0", ALU_DEC, 8'h00, 8'h00, 8'h00, 8'hFF, 4'b0101);
    alu("dec_80", ALU_DEC, 8'h80, 8'h00, 8'h00, 8'h7F, 4'b1000);
    alu("lsl_80", ALU_LSL, 8'h80, 8'h00, 8'h00, 8'h00, 4'b0011);
    alu("lsr_01", ALU_LSR, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0011);
    alu("asr_80", ALU_ASR, 8'h80, 8'h00, 8'h00, 8'hC0, 4'b0100);
    alu("rol_81", ALU_ROL, 8'h81, 8'h00, 8'h00, 8'h03, 4'b0001);
    alu("ror_01", ALU_ROR, 8'h01, 8'h00, 8'h00, 8'h80, 4'b0101);
    alu("pass_0", ALU_PASS, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0010);
    alu("pass_5a", ALU_PASS, 8'h5A, 8'h00, 8'h00, 8'h5A, 4'b0000);
    rst = 1;
    bus.rf_write_en = 1; bus.rf_rc = 3; bus.rf_wdata = 8'hEE; bus.rf_whi = 8'hEE;
    bus.pc_jump = 1; bus.pc_jump_addr = 8'h99; bus.rf_read_en = 1; bus.rf_ra = 3; bus.rf_rb = 3;
    step();
    chk("rst_mid_pc", 20'(bus.pc), 20'h0);
    chk("rst_mid_hi", 20'(bus.rf_hi), 20'h0);
    chk("rst_mid_rd", 20'({bus.rf_rdata_a, bus.rf_rdata_b}), 20'h0);
    rst = 0;
    bus.rf_write_en = 0; bus.pc_jump = 0; bus.rf_ra = 3; bus.rf_rb = 0;
    step();
    chk("rst_mid_regs", 20'({bus.rf_rdata_a, bus.rf_rdata_b}), 20'h0);
    chk("rst_mid_pc_after", 20'(bus.pc), 20'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
